msg_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the design's single character transmitter between up to NREQ message sources. It grants one source at a time, forwards that source's bytes to the transmitter under a valid/ready handshake, and counts the message length down to zero. It exports `chars_remaining` and `which_state` for the top-level debug outputs. It sits between the per-source message generators and the serializer inside `tt_um_*` top.

---
 rtl/msg_tx_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/msg_tx_scheduler.sv | 151 +++++++++++++++
 tb/tb_msg_tx_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/msg_tx_pkg.sv
// Shared types for the message transmit scheduler: FSM state codes, character
// width and a one-hot to index helper.
package msg_tx_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_ARB  = 4'd1,
        ST_LOAD = 4'd2,
        ST_SEND = 4'd3,
        ST_GAP  = 4'd4
    } state_e;

    // Converts a one-hot vector of up to 8 bits into its bit index.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (onehot[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after `last`, wrapping
// at NREQ, wins. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         winner
);

    localparam int IDX_W = $clog2(NREQ);

    logic               found_s;
    logic [IDX_W-1:0]   idx_s;

    // Walk the requesters in priority order starting just after the last owner.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_s         = IDX_W'((int'(last) + i) % NREQ);
            winner[idx_s] = req[idx_s] & ~found_s;
            found_s       = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Shares one character transmitter between NREQ message sources: round-robin
// grant, byte pass-through under valid/ready, length countdown and a post-message gap.
module msg_tx_scheduler
    import msg_tx_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [NREQ-1:0]        req,
    input  logic [8*NREQ-1:0]      req_len,
    input  logic [8*NREQ-1:0]      src_data,
    input  logic [NREQ-1:0]        src_valid,
    output logic [NREQ-1:0]        src_ready,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [7:0]             chars_remaining,
    output logic [3:0]             which_state,
    output logic                   busy
);

    localparam int               IDX_W    = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
    // With no gap configured, message completion returns straight to IDLE.
    localparam state_e           POST_MSG = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_e              state_r;
    state_e              next_state_s;
    logic [NREQ-1:0]     grant_r;
    logic [NREQ-1:0]     done_r;
    logic [NREQ-1:0]     winner_s;
    logic [NREQ-1:0]     done_set_s;
    logic [IDX_W-1:0]    last_r;
    logic [CHAR_W-1:0]   chars_r;
    logic [CHAR_W-1:0]   gap_cnt_r;
    logic [CHAR_W-1:0]   len_sel_s;
    logic                send_s;
    logic                xfer_s;
    logic                last_xfer_s;
    logic                len_zero_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req    (req),
        .last   (last_r),
        .winner (winner_s)
    );

    // Decode the owner's length, transfer events and end-of-message pulses.
    always_comb begin
        send_s                = (state_r == ST_SEND);
        len_sel_s             = req_len[int'(last_r)*CHAR_W +: CHAR_W];
        xfer_s                = ena & send_s & src_valid[last_r] & tx_ready;
        last_xfer_s           = xfer_s & (chars_r == 8'd1);
        len_zero_s            = (state_r == ST_LOAD) & (len_sel_s == 8'd0);
        done_set_s            = '0;
        done_set_s[last_r]    = ena & (last_xfer_s | len_zero_s);
    end

    // FSM state register; ena low freezes the machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (ena) begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: next_state_s = (|req) ? ST_ARB : ST_IDLE;
            ST_ARB:  next_state_s = (|winner_s) ? ST_LOAD : ST_IDLE;
            ST_LOAD: next_state_s = (len_sel_s == 8'd0) ? POST_MSG : ST_SEND;
            ST_SEND: next_state_s = last_xfer_s ? POST_MSG : ST_SEND;
            ST_GAP:  next_state_s = (gap_cnt_r == 8'd0) ? ST_IDLE : ST_GAP;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Grant, round-robin pointer, byte countdown and gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r   <= '0;
            last_r    <= LAST_RST;
            chars_r   <= 8'd0;
            gap_cnt_r <= 8'd0;
        end else if (ena) begin
            case (state_r)
                ST_ARB: begin
                    if (|winner_s) begin
                        grant_r <= winner_s;
                        last_r  <= IDX_W'(onehot_to_idx(8'(winner_s)));
                    end
                end
                ST_LOAD: begin
                    chars_r <= len_sel_s;
                    if (len_sel_s == 8'd0) begin
                        grant_r <= '0;
                    end
                end
                ST_SEND: begin
                    if (xfer_s && (chars_r != 8'd0)) begin
                        chars_r <= chars_r - 8'd1;
                    end
                    if (last_xfer_s) begin
                        grant_r <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r != 8'd0) begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                end
            endcase
            if ((next_state_s == ST_GAP) && (state_r != ST_GAP)) begin
                gap_cnt_r <= 8'(GAP_CYCLES - 1);
            end
        end
    end

    // One-cycle done pulse; never stretched by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= '0;
        end else begin
            done_r <= done_set_s;
        end
    end

    // FSM outputs: registered status plus the SEND-phase pass-through.
    always_comb begin
        grant              = grant_r;
        done               = done_r;
        chars_remaining    = chars_r;
        which_state        = 4'(state_r);
        busy               = (state_r != ST_IDLE);
        tx_valid           = ena & send_s & src_valid[last_r];
        tx_data            = send_s ? src_data[int'(last_r)*CHAR_W +: CHAR_W] : 8'd0;
        src_ready          = '0;
        src_ready[last_r]  = ena & send_s & tx_ready;
    end

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Self-checking bench for msg_tx_scheduler: directed scenarios plus randomized
// messages checked against a transaction-level round-robin reference model.
module tb_msg_tx_scheduler;

    localparam int NREQ = 4;
    localparam int GAP  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b0;
    logic                tx_ready = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     src_valid = '0;
    logic [8*NREQ-1:0]   req_len = '0;
    logic [8*NREQ-1:0]   src_data = '0;
    logic [NREQ-1:0]     src_ready;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic [7:0]          tx_data;
    logic [7:0]          chars_remaining;
    logic                tx_valid;
    logic                busy;
    logic [3:0]          which_state;

    int n_checks = 0;
    int n_errors = 0;
    int exp_last = NREQ - 1;

    msg_tx_scheduler #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .req             (req),
        .req_len         (req_len),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .grant           (grant),
        .done            (done),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .chars_remaining (chars_remaining),
        .which_state     (which_state),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Reference arbiter: first requester after the previous owner, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] m);
        for (int i = 1; i <= NREQ; i++) begin
            if (m[(exp_last + i) % NREQ]) return (exp_last + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_send(input int mode, input int k);
        src_data = {$urandom, $urandom};
        case (mode)
            1: begin
                ena       = ($urandom_range(0, 3) != 0);
                src_valid = 4'($urandom);
                tx_ready  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            end
            2: begin
                ena = 1'b1; src_valid = '1;
                tx_ready = ((k % 4) == 0) || ((k % 4) == 3);
            end
            3: begin
                ena = !((k >= 1) && (k < 6)); src_valid = '1; tx_ready = 1'b1;
            end
            default: begin
                ena = 1'b1; src_valid = '1; tx_ready = 1'b1;
            end
        endcase
    endtask

    // One full message starting in an IDLE cycle and ending at the next IDLE cycle.
    task automatic serve(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] lens,
                         input int mode, input int abort_at);
        int w, len, xfers, k;
        logic [31:0] onehot;
        req = mask; req_len = lens; ena = 1'b1; src_valid = '0; tx_ready = 1'b0;
        #1;
        check_eq("idle_state", which_state, 0);
        check_eq("idle_busy", busy, 0);
        w = rr_pick(mask);
        len = lens[8*w +: 8];
        onehot = 32'd1 << w;
        next_cycle(); #1;
        check_eq("arb_state", which_state, 1);
        check_eq("arb_grant", grant, 0);
        exp_last = w;
        next_cycle(); #1;
        check_eq("load_state", which_state, 2);
        check_eq("load_grant", grant, onehot);
        check_eq("load_txvalid", tx_valid, 0);
        check_eq("load_srcready", src_ready, 0);
        next_cycle();
        xfers = 0; k = 0;
        while ((xfers < len) && (k < 400)) begin
            drive_send(mode, k);
            #1;
            if (xfers == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_grant", grant, 0);
                check_eq("rst_state", which_state, 0);
                check_eq("rst_chars", chars_remaining, 0);
                check_eq("rst_txvalid", tx_valid, 0);
                check_eq("rst_srcready", src_ready, 0);
                rst_n = 1'b1; req = '0; ena = 1'b1;
                exp_last = NREQ - 1;
                next_cycle();
                return;
            end
            check_eq("send_state", which_state, 3);
            check_eq("send_chars", chars_remaining, len - xfers);
            check_eq("send_grant", grant, onehot);
            check_eq("send_done", done, 0);
            check_eq("send_txvalid", tx_valid, ena & src_valid[w]);
            check_eq("send_srcready", src_ready, (ena & tx_ready) ? onehot : 32'd0);
            if (ena && src_valid[w]) check_eq("send_txdata", tx_data, src_data[8*w +: 8]);
            if (ena && src_valid[w] && tx_ready) xfers++;
            k++;
            next_cycle();
        end
        check_eq("send_count", xfers, len);
        ena = 1'b1; src_valid = '0; tx_ready = 1'b0;
        #1;
        check_eq("done_pulse", done, onehot);
        check_eq("done_grant", grant, 0);
        check_eq("done_state", which_state, 4);
        check_eq("done_chars", chars_remaining, 0);
        check_eq("done_txvalid", tx_valid, 0);
        next_cycle(); #1;
        check_eq("gap_state", which_state, 4);
        check_eq("gap_done", done, 0);
        next_cycle();
    endtask

    initial begin
        logic [8*NREQ-1:0] lens;
        #3;
        check_eq("reset_grant", grant, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_srcready", src_ready, 0);
        check_eq("reset_txvalid", tx_valid, 0);
        check_eq("reset_txdata", tx_data, 0);
        check_eq("reset_chars", chars_remaining, 0);
        check_eq("reset_state", which_state, 0);
        check_eq("reset_busy", busy, 0);
        rst_n = 1'b1;
        next_cycle();

        serve(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 0, -1);
        for (int i = 0; i < 5; i++) serve(4'b1111, {8'd1, 8'd1, 8'd1, 8'd1}, 0, -1);
        serve(4'b0001, {8'd0, 8'd0, 8'd0, 8'd2}, 2, -1);
        serve(4'b0010, {8'd4, 8'd4, 8'd0, 8'd4}, 0, -1);
        serve(4'b1000, {8'd6, 8'd0, 8'd0, 8'd0}, 3, -1);

        // Request withdrawn while arbitrating: back to IDLE with no grant.
        req = 4'b0100; ena = 1'b1;
        #1;
        check_eq("drop_idle", which_state, 0);
        next_cycle();
        req = '0;
        #1;
        check_eq("drop_arb", which_state, 1);
        next_cycle(); #1;
        check_eq("drop_back_idle", which_state, 0);
        check_eq("drop_grant", grant, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) lens[8*i +: 8] = 8'($urandom_range(0, 5));
            serve(4'($urandom_range(1, 15)), lens, 1, -1);
        end

        serve(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 0, 2);
        serve(4'b1111, {8'd1, 8'd1, 8'd1, 8'd1}, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
